// File: rtl/cpu_bus_responder_pkg.sv
// Shared bus definitions: responder state encoding and timeout defaults.
// Also imported by address_decoder.
package cpu_bus_responder_pkg;

    // Responder transaction states
    typedef enum logic [2:0] {
        StIdle,
        StWaitDmem,
        StWaitHwregs,
        StWaitImem,
        StErr
    } state_e;

    // Default wait-state limit before a timeout error (valid range 2..65535)
    localparam int unsigned TimeoutCyclesDefault = 255;

    // Width of the optional wait-state counter
    localparam int unsigned TimeoutCntWidth = 16;

endpackage

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: accepts one CPU bus cycle at a time, routes it to the
// decoded target, waits for that target's ack and returns a registered
// response. Unmapped or error-selected accesses complete with bus_error.
// Optional feature macro: CPU_BUS_TIMEOUT_EN (wait-state timeout counter).
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_request,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic        dmem_request,
    input  logic        hwregs_request,
    input  logic        imem_request,
    input  logic        error_request,
    input  logic        dmem_ack,
    input  logic        hwregs_ack,
    input  logic        imem_ack,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] hwregs_rdata,
    input  logic [31:0] imem_rdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        bus_error,
    output logic [31:0] bus_error_address
);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    // Ack/rdata of the target currently being waited on
    logic        wait_ack;
    logic [31:0] wait_rdata;

`ifdef CPU_BUS_TIMEOUT_EN
    // Counter value on the last permitted wait cycle; ack in that cycle still wins
    localparam logic [TimeoutCntWidth-1:0] TimeoutLast = TimeoutCntWidth'(TIMEOUT_CYCLES - 1);

    logic [TimeoutCntWidth-1:0] cnt_q, cnt_d;
`endif

    // Select the ack and read data belonging to the outstanding target
    always_comb begin
        wait_ack   = 1'b0;
        wait_rdata = 32'h0;
        case (state_q)
            StWaitDmem: begin
                wait_ack   = dmem_ack;
                wait_rdata = dmem_rdata;
            end
            StWaitHwregs: begin
                wait_ack   = hwregs_ack;
                wait_rdata = hwregs_rdata;
            end
            StWaitImem: begin
                wait_ack   = imem_ack;
                wait_rdata = imem_rdata;
            end
            default: begin
                wait_ack   = 1'b0;
                wait_rdata = 32'h0;
            end
        endcase
    end

    // Next-state and registered-response logic
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        ack_d      = 1'b0;
        rdata_d    = 32'h0;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
`ifdef CPU_BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (cpu_request) begin
                    write_d = cpu_write;
                    addr_d  = cpu_address;
`ifdef CPU_BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    // Fixed priority; no select at all is treated as an error access
                    if (dmem_request) begin
                        state_d = StWaitDmem;
                    end else if (hwregs_request) begin
                        state_d = StWaitHwregs;
                    end else if (imem_request) begin
                        state_d = StWaitImem;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StWaitDmem, StWaitHwregs, StWaitImem: begin
                if (wait_ack) begin
                    ack_d   = 1'b1;
                    rdata_d = write_q ? 32'h0 : wait_rdata;
                    state_d = StIdle;
                end
`ifdef CPU_BUS_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    ack_d      = 1'b1;
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StErr: begin
                ack_d      = 1'b1;
                err_d      = 1'b1;
                err_addr_d = addr_q;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and response registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            addr_q     <= 32'h0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

`ifdef CPU_BUS_TIMEOUT_EN
    // Wait-state counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Outputs; busy decodes straight from state
    always_comb begin
        cpu_ack           = ack_q;
        cpu_rdata         = rdata_q;
        bus_error         = err_q;
        bus_error_address = err_addr_q;
        cpu_busy          = (state_q != StIdle);
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed self-checking bench for cpu_bus_responder.
module tb_cpu_bus_responder;

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int unsigned TbTimeout = 4;
`else
    localparam int unsigned TbTimeout = 255;
`endif

    logic        clock;
    logic        reset_n;
    logic        cpu_request;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic        dmem_request, hwregs_request, imem_request, error_request;
    logic        dmem_ack, hwregs_ack, imem_ack;
    logic [31:0] dmem_rdata, hwregs_rdata, imem_rdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic        bus_error;
    logic [31:0] bus_error_address;

    int checks = 0;
    int errors = 0;

    cpu_bus_responder #(
        .TIMEOUT_CYCLES(TbTimeout)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cpu_request      (cpu_request),
        .cpu_write        (cpu_write),
        .cpu_address      (cpu_address),
        .dmem_request     (dmem_request),
        .hwregs_request   (hwregs_request),
        .imem_request     (imem_request),
        .error_request    (error_request),
        .dmem_ack         (dmem_ack),
        .hwregs_ack       (hwregs_ack),
        .imem_ack         (imem_ack),
        .dmem_rdata       (dmem_rdata),
        .hwregs_rdata     (hwregs_rdata),
        .imem_rdata       (imem_rdata),
        .cpu_ack          (cpu_ack),
        .cpu_rdata        (cpu_rdata),
        .cpu_busy         (cpu_busy),
        .bus_error        (bus_error),
        .bus_error_address(bus_error_address)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue a one-cycle request; sel = {dmem, hwregs, imem, error}
    task automatic start(input logic [3:0] sel, input logic wr, input logic [31:0] addr);
        cpu_request = 1'b1;
        cpu_write   = wr;
        cpu_address = addr;
        {dmem_request, hwregs_request, imem_request, error_request} = sel;
        tick();
        cpu_request = 1'b0;
        cpu_write   = 1'b0;
        {dmem_request, hwregs_request, imem_request, error_request} = 4'b0000;
    endtask

    // One-cycle ack pulse; acks = {dmem, hwregs, imem}
    task automatic pulse_ack(input logic [2:0] acks, input logic [31:0] data);
        {dmem_ack, hwregs_ack, imem_ack} = acks;
        dmem_rdata   = data;
        hwregs_rdata = data;
        imem_rdata   = data;
        tick();
        {dmem_ack, hwregs_ack, imem_ack} = 3'b000;
        dmem_rdata   = 32'h0;
        hwregs_rdata = 32'h0;
        imem_rdata   = 32'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        cpu_request = 1'b0; cpu_write = 1'b0; cpu_address = 32'h0;
        {dmem_request, hwregs_request, imem_request, error_request} = 4'b0000;
        {dmem_ack, hwregs_ack, imem_ack} = 3'b000;
        dmem_rdata = 32'h0; hwregs_rdata = 32'h0; imem_rdata = 32'h0;
        #3 reset_n = 1'b0;
        #2;
        checks++;
        if ({cpu_ack, bus_error, cpu_busy, cpu_rdata, bus_error_address} !== 67'h0) begin
            errors++;
            $display("FAIL reset: ack=%b err=%b busy=%b rdata=%h eaddr=%h, want all 0",
                     cpu_ack, bus_error, cpu_busy, cpu_rdata, bus_error_address);
        end
        @(negedge clock) reset_n = 1'b1;
        tick();
    endtask

    task automatic test_dmem_read();
        start(4'b1000, 1'b0, 32'h0000_0100);
        checks++;
        if ({cpu_ack, bus_error, cpu_busy} !== 3'b001) begin
            errors++;
            $display("FAIL dmem_accept: ack/err/busy=%b want 001", {cpu_ack, bus_error, cpu_busy});
        end
        tick();
        pulse_ack(3'b100, 32'hDEAD_BEEF);
        checks++;
        if ({cpu_ack, bus_error, cpu_busy, cpu_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL dmem_read: ack/err/busy=%b rdata=%h want 100 deadbeef",
                     {cpu_ack, bus_error, cpu_busy}, cpu_rdata);
        end
        tick();
        checks++;
        if ({cpu_ack, cpu_rdata} !== 33'h0) begin
            errors++;
            $display("FAIL dmem_after: ack=%b rdata=%h want 0 0", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_error_request();
        start(4'b0001, 1'b0, 32'h8000_0000);
        checks++;
        if ({cpu_ack, bus_error, cpu_busy} !== 3'b001) begin
            errors++;
            $display("FAIL err_state: ack/err/busy=%b want 001", {cpu_ack, bus_error, cpu_busy});
        end
        tick();
        checks++;
        if ({cpu_ack, bus_error, cpu_busy, cpu_rdata, bus_error_address}
                !== {3'b110, 32'h0, 32'h8000_0000}) begin
            errors++;
            $display("FAIL err_resp: ack/err/busy=%b rdata=%h eaddr=%h want 110 0 80000000",
                     {cpu_ack, bus_error, cpu_busy}, cpu_rdata, bus_error_address);
        end
        tick();
        checks++;
        if ({cpu_ack, bus_error, bus_error_address} !== {2'b00, 32'h8000_0000}) begin
            errors++;
            $display("FAIL err_hold: ack/err=%b eaddr=%h want 00 80000000",
                     {cpu_ack, bus_error}, bus_error_address);
        end
    endtask

    task automatic test_no_select();
        start(4'b0000, 1'b1, 32'h0000_0044);
        tick();
        checks++;
        if ({cpu_ack, bus_error, cpu_rdata, bus_error_address} !== {2'b11, 32'h0, 32'h0000_0044}) begin
            errors++;
            $display("FAIL no_select: ack/err=%b rdata=%h eaddr=%h want 11 0 00000044",
                     {cpu_ack, bus_error}, cpu_rdata, bus_error_address);
        end
        tick();
    endtask

    task automatic test_priority();
        // All selects high: dmem must win, so hwregs/imem acks are stray
        start(4'b1111, 1'b0, 32'h0000_0200);
        pulse_ack(3'b011, 32'hBAD0_BAD0);
        checks++;
        if ({cpu_ack, bus_error, cpu_busy} !== 3'b001) begin
            errors++;
            $display("FAIL prio_dmem_stray: ack/err/busy=%b want 001", {cpu_ack, bus_error, cpu_busy});
        end
        pulse_ack(3'b100, 32'h1111_1111);
        checks++;
        if ({cpu_ack, bus_error, cpu_rdata} !== {2'b10, 32'h1111_1111}) begin
            errors++;
            $display("FAIL prio_dmem: ack/err=%b rdata=%h want 10 11111111",
                     {cpu_ack, bus_error}, cpu_rdata);
        end
        tick();
        // hwregs beats imem and error
        start(4'b0111, 1'b0, 32'h0000_0300);
        pulse_ack(3'b001, 32'hBAD1_BAD1);
        pulse_ack(3'b010, 32'h2222_2222);
        checks++;
        if ({cpu_ack, bus_error, cpu_rdata} !== {2'b10, 32'h2222_2222}) begin
            errors++;
            $display("FAIL prio_hwregs: ack/err=%b rdata=%h want 10 22222222",
                     {cpu_ack, bus_error}, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_stray_ack();
        start(4'b0100, 1'b0, 32'h0000_0400);
        pulse_ack(3'b001, 32'hCAFE_CAFE);
        checks++;
        if ({cpu_ack, cpu_busy} !== 2'b01) begin
            errors++;
            $display("FAIL stray_ack: ack/busy=%b want 01", {cpu_ack, cpu_busy});
        end
        tick();
        pulse_ack(3'b010, 32'h1234_5678);
        checks++;
        if ({cpu_ack, bus_error, cpu_rdata} !== {2'b10, 32'h1234_5678}) begin
            errors++;
            $display("FAIL stray_done: ack/err=%b rdata=%h want 10 12345678",
                     {cpu_ack, bus_error}, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_write();
        start(4'b0100, 1'b1, 32'h0000_0500);
        pulse_ack(3'b010, 32'hFFFF_FFFF);
        checks++;
        if ({cpu_ack, bus_error, cpu_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL write_rdata: ack/err=%b rdata=%h want 10 0", {cpu_ack, bus_error}, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_ignored_acks();
        // Ack in IDLE
        pulse_ack(3'b111, 32'h5555_5555);
        checks++;
        if ({cpu_ack, cpu_busy, cpu_rdata} !== 34'h0) begin
            errors++;
            $display("FAIL idle_ack: ack/busy=%b rdata=%h want 00 0", {cpu_ack, cpu_busy}, cpu_rdata);
        end
        // Ack coinciding with the request cycle
        dmem_ack = 1'b1;
        dmem_rdata = 32'h6666_6666;
        start(4'b1000, 1'b0, 32'h0000_0600);
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        tick();
        checks++;
        if ({cpu_ack, cpu_busy} !== 2'b01) begin
            errors++;
            $display("FAIL req_cycle_ack: ack/busy=%b want 01", {cpu_ack, cpu_busy});
        end
        // A request while busy must not disturb the outstanding access
        cpu_request = 1'b1;
        error_request = 1'b1;
        cpu_address = 32'hEEEE_0000;
        tick();
        cpu_request = 1'b0;
        error_request = 1'b0;
        pulse_ack(3'b100, 32'h7777_7777);
        checks++;
        if ({cpu_ack, bus_error, cpu_rdata, bus_error_address}
                !== {2'b10, 32'h7777_7777, 32'h0000_0044}) begin
            errors++;
            $display("FAIL busy_request: ack/err=%b rdata=%h eaddr=%h want 10 77777777 00000044",
                     {cpu_ack, bus_error}, cpu_rdata, bus_error_address);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        start(4'b1000, 1'b0, 32'h0000_0700);
        pulse_ack(3'b100, 32'hA5A5_A5A5);
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL b2b_first: ack=%b rdata=%h want 1 a5a5a5a5", cpu_ack, cpu_rdata);
        end
        start(4'b0010, 1'b0, 32'h0000_0800);
        checks++;
        if ({cpu_ack, cpu_busy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_accept: ack/busy=%b want 01", {cpu_ack, cpu_busy});
        end
        pulse_ack(3'b001, 32'h5A5A_5A5A);
        checks++;
        if ({cpu_ack, bus_error, cpu_rdata} !== {2'b10, 32'h5A5A_5A5A}) begin
            errors++;
            $display("FAIL b2b_second: ack/err=%b rdata=%h want 10 5a5a5a5a",
                     {cpu_ack, bus_error}, cpu_rdata);
        end
        tick();
    endtask

`ifdef CPU_BUS_TIMEOUT_EN
    task automatic test_timeout();
        start(4'b1000, 1'b0, 32'h0000_0900);
        tick(); tick(); tick();
        checks++;
        if ({cpu_ack, cpu_busy} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_wait4: ack/busy=%b want 01", {cpu_ack, cpu_busy});
        end
        tick();
        checks++;
        if ({cpu_ack, bus_error, cpu_busy, cpu_rdata, bus_error_address}
                !== {3'b110, 32'h0, 32'h0000_0900}) begin
            errors++;
            $display("FAIL timeout_resp: ack/err/busy=%b rdata=%h eaddr=%h want 110 0 00000900",
                     {cpu_ack, bus_error, cpu_busy}, cpu_rdata, bus_error_address);
        end
        pulse_ack(3'b100, 32'hABCD_0000);
        checks++;
        if ({cpu_ack, bus_error, cpu_busy} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_late_ack: ack/err/busy=%b want 000", {cpu_ack, bus_error, cpu_busy});
        end
        // Ack on the last permitted wait cycle wins over the timeout
        start(4'b1000, 1'b0, 32'h0000_0A00);
        tick(); tick(); tick();
        pulse_ack(3'b100, 32'hBEEF_0001);
        checks++;
        if ({cpu_ack, bus_error, cpu_rdata} !== {2'b10, 32'hBEEF_0001}) begin
            errors++;
            $display("FAIL timeout_ack_wins: ack/err=%b rdata=%h want 10 beef0001",
                     {cpu_ack, bus_error}, cpu_rdata);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int early_ack;
        early_ack = 0;
        start(4'b1000, 1'b0, 32'h0000_0900);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (cpu_ack || !cpu_busy) early_ack++;
        end
        checks++;
        if (early_ack !== 0) begin
            errors++;
            $display("FAIL no_timeout: %0d cycles ended the wait early, want 0", early_ack);
        end
        pulse_ack(3'b100, 32'h0BAD_F00D);
        checks++;
        if ({cpu_ack, bus_error, cpu_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL no_timeout_done: ack/err=%b rdata=%h want 10 0badf00d",
                     {cpu_ack, bus_error}, cpu_rdata);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        start(4'b0010, 1'b0, 32'h0000_0B00);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_ack, bus_error, cpu_busy, cpu_rdata, bus_error_address} !== 67'h0) begin
            errors++;
            $display("FAIL reset_mid: ack=%b err=%b busy=%b rdata=%h eaddr=%h, want all 0",
                     cpu_ack, bus_error, cpu_busy, cpu_rdata, bus_error_address);
        end
        @(negedge clock) reset_n = 1'b1;
        tick();
        pulse_ack(3'b001, 32'h9999_9999);
        checks++;
        if ({cpu_ack, bus_error, cpu_busy, cpu_rdata} !== 35'h0) begin
            errors++;
            $display("FAIL reset_late_ack: ack/err/busy=%b rdata=%h want 000 0",
                     {cpu_ack, bus_error, cpu_busy}, cpu_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_dmem_read();
        test_error_request();
        test_no_select();
        test_priority();
        test_stray_ack();
        test_write();
        test_ignored_acks();
        test_back_to_back();
`ifdef CPU_BUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
